// File: rtl/decap_head.sv
`default_nettype none
// ============================================================================
//  Module      : decap_head
//  Description : Strips a leading encapsulation field of programmable length
//                (in SHIFT_WIDTH units) from a tagged head-slice stream. The
//                stripped field goes out on a side channel, and the rest of
//                the head is re-aligned across slice boundaries.
//  Option      : DECAP_ERR_CHECK_EN - builds a sticky protocol error flag
//                (o_err); when undefined, o_err is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module decap_head #(
  parameter int HEAD_WIDTH       = 512,
  parameter int TAG_WIDTH        = 4,
  parameter int TAG_START_BIT    = 0,
  parameter int TAG_TAIL_BIT     = 1,
  parameter int TAG_VALID_BIT    = 2,
  parameter int SHIFT_WIDTH      = 16,
  parameter int HEAD_SHIFT_WIDTH = 5
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [HEAD_WIDTH+TAG_WIDTH-1:0] i_head,
  input  logic [HEAD_SHIFT_WIDTH-1:0]     i_decapLength,
  output logic [HEAD_WIDTH+TAG_WIDTH-1:0] o_head,
  output logic [HEAD_WIDTH-1:0]           o_encapField,
  output logic [HEAD_SHIFT_WIDTH-1:0]     o_encapLength,
  output logic                            o_encapValid,
  output logic                            o_err
);

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  // Window of HEAD_WIDTH bits taken from {p,n}, starting l units below the MSB.
  function automatic logic [HEAD_WIDTH-1:0] f_shift(
    input logic [HEAD_WIDTH-1:0]       p,
    input logic [HEAD_WIDTH-1:0]       n,
    input logic [HEAD_SHIFT_WIDTH-1:0] l
  );
    logic [2*HEAD_WIDTH-1:0] cat;
    cat = {p, n} << (l * SHIFT_WIDTH);
    return cat[2*HEAD_WIDTH-1 -: HEAD_WIDTH];
  endfunction

  // Keep only the top l units of d, zeroing everything below.
  function automatic logic [HEAD_WIDTH-1:0] f_field(
    input logic [HEAD_WIDTH-1:0]       d,
    input logic [HEAD_SHIFT_WIDTH-1:0] l
  );
    logic [HEAD_WIDTH-1:0] mask;
    mask = ~({HEAD_WIDTH{1'b1}} >> (l * SHIFT_WIDTH));
    return d & mask;
  endfunction

  // --------------------------------------------------------------------------
  // Input decode
  // --------------------------------------------------------------------------
  logic [HEAD_WIDTH-1:0] w_data;
  logic [TAG_WIDTH-1:0]  w_tag;
  logic                  w_vld;
  logic                  w_start;
  logic                  w_tail;
  logic                  w_unused_tag;

  assign w_data       = i_head[HEAD_WIDTH-1:0];
  assign w_tag        = i_head[HEAD_WIDTH +: TAG_WIDTH];
  assign w_vld        = w_tag[TAG_VALID_BIT];
  // Start and tail are only meaningful when the slice is valid.
  assign w_start      = w_vld & w_tag[TAG_START_BIT];
  assign w_tail       = w_vld & w_tag[TAG_TAIL_BIT];
  assign w_unused_tag = ^w_tag;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [HEAD_WIDTH-1:0]           prev_q,  prev_d;
  logic [HEAD_SHIFT_WIDTH-1:0]     len_q,   len_d;
  logic                            inpkt_q, inpkt_d;
  logic                            first_q, first_d;
  logic                            flush_q, flush_d;

  logic [HEAD_WIDTH+TAG_WIDTH-1:0] head_q,  head_d;
  logic [HEAD_WIDTH-1:0]           field_q, field_d;
  logic [HEAD_SHIFT_WIDTH-1:0]     elen_q,  elen_d;
  logic                            evld_q,  evld_d;

  logic                            w_emit;
  logic                            w_emit_tail;
  logic [HEAD_WIDTH-1:0]           w_emit_data;
  logic [TAG_WIDTH-1:0]            w_out_tag;

  // Next-state decode: start slice has priority (it never emits a head slice
  // of its own, so it can share an edge with a flush or a forced termination).
  always_comb begin
    prev_d      = prev_q;
    len_d       = len_q;
    inpkt_d     = inpkt_q;
    first_d     = first_q;
    flush_d     = flush_q;
    field_d     = field_q;
    elen_d      = elen_q;
    evld_d      = 1'b0;
    w_emit      = 1'b0;
    w_emit_tail = 1'b0;
    w_emit_data = '0;

    if (w_start) begin
      // Close out any held slice: pending flush, or an unterminated packet.
      if (flush_q || inpkt_q) begin
        w_emit      = 1'b1;
        w_emit_tail = 1'b1;
        w_emit_data = f_shift(prev_q, '0, len_q);
      end
      prev_d  = w_data;
      len_d   = i_decapLength;
      first_d = 1'b1;
      // A start+tail slice goes straight to flush and leaves the packet idle.
      inpkt_d = ~w_tail;
      flush_d = w_tail;
      field_d = f_field(w_data, i_decapLength);
      elen_d  = i_decapLength;
      evld_d  = 1'b1;
    end else if (flush_q) begin
      w_emit      = 1'b1;
      w_emit_tail = 1'b1;
      w_emit_data = f_shift(prev_q, '0, len_q);
      flush_d     = 1'b0;
      first_d     = 1'b0;
    end else if (w_vld && inpkt_q) begin
      w_emit      = 1'b1;
      w_emit_data = f_shift(prev_q, w_data, len_q);
      prev_d      = w_data;
      first_d     = 1'b0;
      if (w_tail) begin
        flush_d = 1'b1;
        inpkt_d = 1'b0;
      end
    end
    // Valid non-start slices while idle fall through and are dropped.
  end

  // Output tag assembly; the whole slice is zero on cycles with no emission.
  always_comb begin
    w_out_tag                = '0;
    w_out_tag[TAG_VALID_BIT] = w_emit;
    w_out_tag[TAG_START_BIT] = w_emit & first_q;
    w_out_tag[TAG_TAIL_BIT]  = w_emit & w_emit_tail;
    head_d = w_emit ? {w_out_tag, w_emit_data} : '0;
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev_q  <= '0;
      len_q   <= '0;
      inpkt_q <= 1'b0;
      first_q <= 1'b0;
      flush_q <= 1'b0;
      head_q  <= '0;
      field_q <= '0;
      elen_q  <= '0;
      evld_q  <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      len_q   <= len_d;
      inpkt_q <= inpkt_d;
      first_q <= first_d;
      flush_q <= flush_d;
      head_q  <= head_d;
      field_q <= field_d;
      elen_q  <= elen_d;
      evld_q  <= evld_d;
    end
  end

  assign o_head        = head_q;
  assign o_encapField  = field_q;
  assign o_encapLength = elen_q;
  assign o_encapValid  = evld_q;

  // --------------------------------------------------------------------------
  // Optional sticky protocol error
  // --------------------------------------------------------------------------
`ifdef DECAP_ERR_CHECK_EN
  logic err_q;
  logic w_err_evt;

  assign w_err_evt = (w_start && (inpkt_q || (i_decapLength == '0))) ||
                     (w_vld && !w_start && !inpkt_q);

  // Set on any protocol violation; only reset clears it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      err_q <= 1'b0;
    end else if (w_err_evt) begin
      err_q <= 1'b1;
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decap_head.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decap_head
//  Description : Scoreboard bench for decap_head. Stimulus pushes expected
//                head slices and encap records into queues; a monitor pops
//                and compares them whenever the DUT presents an output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decap_head;

  localparam int HW = 512;
  localparam int TW = 4;
  localparam int SW = 16;
  localparam int LW = 5;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic [HW+TW-1:0]  i_head;
  logic [LW-1:0]     i_decapLength;
  logic [HW+TW-1:0]  o_head;
  logic [HW-1:0]     o_encapField;
  logic [LW-1:0]     o_encapLength;
  logic              o_encapValid;
  logic              o_err;

  int tests = 0;
  int fails = 0;

  logic [HW+TW-1:0] head_q[$];
  logic [LW+HW-1:0] encap_q[$];

  decap_head dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_head        (i_head),
    .i_decapLength (i_decapLength),
    .o_head        (o_head),
    .o_encapField  (o_encapField),
    .o_encapLength (o_encapLength),
    .o_encapValid  (o_encapValid),
    .o_err         (o_err)
  );

  always #5 i_clk = ~i_clk;

  // Recognisable slice: every 32-bit word is {seed, word index, 16'hC0DE}.
  function automatic logic [HW-1:0] mk(input logic [7:0] seed);
    logic [HW-1:0] d;
    for (int k = 0; k < HW/32; k++) begin
      d[k*32 +: 32] = {seed, 8'(k), 16'hC0DE};
    end
    return d;
  endfunction

  function automatic logic [HW-1:0] exp_shift(input logic [HW-1:0] p,
                                               input logic [HW-1:0] n,
                                               input int l);
    logic [2*HW-1:0] cat;
    cat = {p, n};
    return cat[2*HW-1-l*SW -: HW];
  endfunction

  function automatic logic [HW-1:0] exp_field(input logic [HW-1:0] d, input int l);
    logic [HW-1:0] f;
    f = '0;
    for (int i = 0; i < l*SW; i++) f[HW-1-i] = d[HW-1-i];
    return f;
  endfunction

  task automatic push_head(input logic [HW-1:0] d, input logic s, input logic t);
    logic [TW-1:0] tag;
    tag = 4'b0100;
    tag[0] = s;
    tag[1] = t;
    head_q.push_back({tag, d});
  endtask

  task automatic push_encap(input logic [HW-1:0] d, input int l);
    encap_q.push_back({LW'(l), exp_field(d, l)});
  endtask

  task automatic step(input logic v, input logic s, input logic t,
                      input logic [HW-1:0] d, input logic [LW-1:0] l);
    logic [TW-1:0] tag;
    tag = '0;
    tag[2] = v;
    tag[0] = s;
    tag[1] = t;
    i_head = {tag, d};
    i_decapLength = l;
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic check(input string name, input logic [HW+TW-1:0] act,
                       input logic [HW+TW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Output monitor: compares each presented output against the scoreboard.
  task automatic monitor();
    logic [HW+TW-1:0] eh;
    logic [LW+HW-1:0] ee;
    forever begin
      @(negedge i_clk);
      if (o_head[HW+2]) begin
        if (head_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL head_extra: got %h expected none", o_head);
        end else begin
          eh = head_q.pop_front();
          check("head", o_head, eh);
        end
      end else if (o_head !== '0) begin
        tests++; fails++;
        $display("FAIL head_idle: got %h expected 0", o_head);
      end
      if (o_encapValid) begin
        if (encap_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL encap_extra: got len %0d expected none", o_encapLength);
        end else begin
          ee = encap_q.pop_front();
          check("encap", {{(TW-LW+LW){1'b0}}, o_encapField} | (HW+TW)'({o_encapLength, {HW{1'b0}}} >> 0),
                (HW+TW)'(ee));
        end
      end
    end
  endtask

  logic [HW-1:0] A, B, C, D, E, F;
  logic          err_exp;

  initial begin
    A = mk(8'hA1); B = mk(8'hB2); C = mk(8'hC3);
    D = mk(8'hD4); E = mk(8'hE5); F = mk(8'hF6);
`ifdef DECAP_ERR_CHECK_EN
    err_exp = 1'b1;
`else
    err_exp = 1'b0;
`endif
    i_rst = 1'b1;
    i_head = '0;
    i_decapLength = '0;
    fork monitor(); join_none

    // Reset state
    @(posedge i_clk); #1;
    @(negedge i_clk);
    check("reset_outputs", (HW+TW)'({o_head, o_encapField, o_encapLength, o_encapValid, o_err} != 0), '0);
    check("reset_head", o_head, '0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    idle(2);

    // 3-slice packet, L=2
    push_encap(A, 2);
    push_head(exp_shift(A, B, 2), 1'b1, 1'b0);
    push_head(exp_shift(B, C, 2), 1'b0, 1'b0);
    push_head(exp_shift(C, '0, 2), 1'b0, 1'b1);
    step(1, 1, 0, A, 5'd2);
    step(1, 0, 0, B, 5'd7);
    step(1, 0, 1, C, 5'd9);
    idle(3);

    // Single slice start+tail, L=4
    push_encap(A, 4);
    push_head(exp_shift(A, '0, 4), 1'b1, 1'b1);
    step(1, 1, 1, A, 5'd4);
    idle(3);
    check("err_clean", (HW+TW)'(o_err), '0);

    // Back-to-back packets: tail flush of #1 shares an edge with encap of #2
    push_encap(A, 1);
    push_head(exp_shift(A, B, 1), 1'b1, 1'b0);
    push_head(exp_shift(B, '0, 1), 1'b0, 1'b1);
    push_encap(C, 3);
    push_head(exp_shift(C, D, 3), 1'b1, 1'b0);
    push_head(exp_shift(D, '0, 3), 1'b0, 1'b1);
    step(1, 1, 0, A, 5'd1);
    step(1, 0, 1, B, 5'd0);
    step(1, 1, 0, C, 5'd3);
    step(1, 0, 1, D, 5'd0);
    idle(3);

    // Start while in-packet terminates the old packet
    push_encap(A, 2);
    push_head(exp_shift(A, B, 2), 1'b1, 1'b0);
    push_head(exp_shift(B, '0, 2), 1'b0, 1'b1);
    push_encap(C, 1);
    push_head(exp_shift(C, D, 1), 1'b1, 1'b0);
    push_head(exp_shift(D, '0, 1), 1'b0, 1'b1);
    step(1, 1, 0, A, 5'd2);
    step(1, 0, 0, B, 5'd0);
    step(1, 1, 0, C, 5'd1);
    step(1, 0, 1, D, 5'd0);
    idle(3);
    check("err_restart", (HW+TW)'(o_err), (HW+TW)'(err_exp));

    // L=0 with a 3-cycle gap (invalid slices carry junk start/tail bits)
    push_encap(E, 0);
    push_head(E, 1'b1, 1'b0);
    push_head(F, 1'b0, 1'b1);
    step(1, 1, 0, E, 5'd0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, D, 5'd6);
    step(1, 0, 1, F, 5'd0);
    idle(3);

    // Valid non-start slice while idle is dropped
    step(1, 0, 1, C, 5'd0);
    idle(2);

    // Reset mid-packet, then a fresh packet
    push_encap(A, 2);
    push_head(exp_shift(A, B, 2), 1'b1, 1'b0);
    step(1, 1, 0, A, 5'd2);
    step(1, 0, 0, B, 5'd0);
    i_rst = 1'b1;
    step(1, 0, 0, C, 5'd0);
    @(negedge i_clk);
    check("midrst_head", o_head, '0);
    check("midrst_encap", (HW+TW)'({o_encapField, o_encapLength, o_encapValid, o_err} != 0), '0);
    step(0, 0, 0, '0, 5'd0);
    i_rst = 1'b0;
    check("err_after_reset", (HW+TW)'(o_err), '0);
    push_encap(E, 5);
    push_head(exp_shift(E, F, 5), 1'b1, 1'b0);
    push_head(exp_shift(F, '0, 5), 1'b0, 1'b1);
    step(1, 1, 0, E, 5'd5);
    step(1, 0, 1, F, 5'd0);
    idle(4);

    tests++;
    if (head_q.size() != 0 || encap_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d head / %0d encap left expected 0", head_q.size(), encap_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
